// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// The system-wide configuration macros below normally come from the shared
// sysconfig.v. Each one is defined here only when it does not already exist,
// so a project-level sysconfig.v read earlier takes precedence.
// The package turns the macros into typed localparams. It also holds the FSM
// state enum, the PC-select enum, the output-register struct and small helper
// functions that the other files use.

`ifndef XLEN
`define XLEN 64
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef TRAP_LEN
`define TRAP_LEN 8
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef TRAP_INST_MISALIGNED
`define TRAP_INST_MISALIGNED 0
`endif
`ifndef TRAP_INST_ACCESS_FAULT
`define TRAP_INST_ACCESS_FAULT 1
`endif
`ifndef CTRLBUS_LEN
`define CTRLBUS_LEN 6
`endif
`ifndef CTRLBUS_PC
`define CTRLBUS_PC 0
`endif

package inst_fetch_pkg;

  localparam int XLEN                   = `XLEN;
  localparam int INST_LEN               = `INST_LEN;
  localparam int TRAP_LEN               = `TRAP_LEN;
  localparam int CTRLBUS_LEN            = `CTRLBUS_LEN;
  localparam int CTRLBUS_PC             = `CTRLBUS_PC;
  localparam int TRAP_INST_MISALIGNED   = `TRAP_INST_MISALIGNED;
  localparam int TRAP_INST_ACCESS_FAULT = `TRAP_INST_ACCESS_FAULT;
  localparam logic [INST_LEN-1:0] INST_NOP = `INST_NOP;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_OUT  = 2'd2,
    FS_KILL = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     addr;
    logic [INST_LEN-1:0] data;
    logic [TRAP_LEN-1:0] trap;
  } fetch_out_t;

  localparam fetch_out_t OUT_INVALID = '{
    valid: 1'b0,
    addr:  {XLEN{1'b0}},
    data:  INST_NOP,
    trap:  {TRAP_LEN{1'b0}}
  };

  // One-hot trap vector with only the given cause bit set.
  function automatic logic [TRAP_LEN-1:0] trap_bit(input int idx);
    logic [TRAP_LEN-1:0] vec;
    vec      = {TRAP_LEN{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Fetch addresses must be 4-byte aligned.
  function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory request/response bundle.
// master : fetch stage (drives the request, receives the response)
// slave  : instruction memory
// Signals:
//   req_valid / req_addr / req_ready   request handshake
//   resp_valid / resp_data / resp_err  single-cycle response, err is qualified
//                                      by resp_valid

interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic                req_valid;
  logic [XLEN-1:0]     req_addr;
  logic                req_ready;
  logic                resp_valid;
  logic [INST_LEN-1:0] resp_data;
  logic                resp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/inst_fetch_pc_gen.sv
// Program counter for the fetch stage: next-PC mux and PC register.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   pc_sel_i        hold / +4 / redirect select from the fetch FSM
//   redirect_pc_i   redirect target
//   pc_o            current PC (registered)
//   pc_next_o       PC the register loads at the next edge

module pc_gen
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         pc_sel_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next-PC select; the +4 wraps silently at the top of the address space.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_i)
      PC_HOLD:     pc_d = pc_q;
      PC_INC:      pc_d = pc_q + XLEN'(3'd4);
      PC_REDIRECT: pc_d = redirect_pc_i;
      default:     pc_d = pc_q;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one outstanding request at a time to the
// instruction memory and presents the fetched instruction (or a fetch trap)
// in a registered output towards IF/ID.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   stall_valid_i[CTRL_IDX]     hold the output register and the PC
//   flush_valid_i[CTRL_IDX]     drop the output, refetch the same PC
//   redirect_valid_i/_pc_i      branch/trap redirect (highest priority)
//   imem                        memory request/response bundle (master side)
//   inst_valid_o, inst_addr_if_o, inst_data_if_o, trap_bus_if_o
//                               presented instruction, registered

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int              CTRL_IDX = CTRLBUS_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CTRLBUS_LEN-1:0] stall_valid_i,
  input  logic [CTRLBUS_LEN-1:0] flush_valid_i,
  input  logic                   redirect_valid_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  inst_fetch_if.master           imem,
  output logic                   inst_valid_o,
  output logic [XLEN-1:0]        inst_addr_if_o,
  output logic [INST_LEN-1:0]    inst_data_if_o,
  output logic [TRAP_LEN-1:0]    trap_bus_if_o
);

  fetch_state_e    state_q, state_d;
  fetch_out_t      out_q, out_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;

  pc_sel_e         pc_sel_s;
  logic [XLEN-1:0] pc_s;
  logic [XLEN-1:0] pc_next_s;
  logic            stall_s;
  logic            flush_s;
  logic            req_fire_s;
  logic            unused_ctrl_s;

  assign stall_s    = stall_valid_i[CTRL_IDX];
  assign flush_s    = flush_valid_i[CTRL_IDX];
  assign req_fire_s = req_valid_q & imem.req_ready;
  // Only this stage's bit of the control buses is meaningful here.
  assign unused_ctrl_s = ^{stall_valid_i, flush_valid_i};

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .pc_sel_i      (pc_sel_s),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_s),
    .pc_next_o     (pc_next_s)
  );

  // Next state, next PC select and next output register.
  // Priority in every state: redirect, then flush, then stall/normal flow.
  // A request accepted (or outstanding) when it is cancelled goes to KILL so
  // its response is swallowed; a response that arrives in the cancelling
  // cycle itself is simply not captured.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    pc_sel_s = PC_HOLD;
    case (state_q)
      FS_IDLE: begin
        if (redirect_valid_i) begin
          pc_sel_s = PC_REDIRECT;
          out_d    = OUT_INVALID;
          state_d  = req_fire_s ? FS_KILL : FS_IDLE;
        end else if (flush_s) begin
          out_d   = OUT_INVALID;
          state_d = req_fire_s ? FS_KILL : FS_IDLE;
        end else if (!pc_aligned(pc_s)) begin
          // No request for a misaligned PC; present the trap directly.
          out_d   = '{valid: 1'b1, addr: pc_s, data: INST_NOP,
                      trap: trap_bit(TRAP_INST_MISALIGNED)};
          state_d = FS_OUT;
        end else if (req_fire_s) begin
          state_d = FS_WAIT;
        end else begin
          state_d = FS_IDLE;
        end
      end
      FS_WAIT: begin
        if (redirect_valid_i) begin
          pc_sel_s = PC_REDIRECT;
          out_d    = OUT_INVALID;
          state_d  = imem.resp_valid ? FS_IDLE : FS_KILL;
        end else if (flush_s) begin
          out_d   = OUT_INVALID;
          state_d = imem.resp_valid ? FS_IDLE : FS_KILL;
        end else if (imem.resp_valid) begin
          out_d   = '{valid: 1'b1, addr: pc_s,
                      data: imem.resp_err ? INST_NOP : imem.resp_data,
                      trap: imem.resp_err ? trap_bit(TRAP_INST_ACCESS_FAULT)
                                          : {TRAP_LEN{1'b0}}};
          state_d = FS_OUT;
        end else begin
          state_d = FS_WAIT;
        end
      end
      FS_OUT: begin
        if (redirect_valid_i) begin
          pc_sel_s = PC_REDIRECT;
          out_d    = OUT_INVALID;
          state_d  = FS_IDLE;
        end else if (flush_s) begin
          out_d   = OUT_INVALID;
          state_d = FS_IDLE;
        end else if (!stall_s) begin
          pc_sel_s = PC_INC;
          out_d    = OUT_INVALID;
          state_d  = FS_IDLE;
        end else begin
          state_d = FS_OUT;
        end
      end
      FS_KILL: begin
        out_d = OUT_INVALID;
        if (redirect_valid_i) begin
          pc_sel_s = PC_REDIRECT;
          state_d  = imem.resp_valid ? FS_IDLE : FS_KILL;
        end else if (imem.resp_valid) begin
          state_d = FS_IDLE;
        end else begin
          state_d = FS_KILL;
        end
      end
      default: begin
        out_d   = OUT_INVALID;
        state_d = FS_IDLE;
      end
    endcase
    // The request is registered: it is raised for the PC the stage will hold
    // in IDLE, so its address cannot change while it waits for ready.
    req_valid_d = (state_d == FS_IDLE) && pc_aligned(pc_next_s);
    req_addr_d  = pc_next_s;
  end

  // State, request and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FS_IDLE;
      out_q       <= OUT_INVALID;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  assign imem.req_valid = req_valid_q;
  assign imem.req_addr  = req_addr_q;
  assign inst_valid_o   = out_q.valid;
  assign inst_addr_if_o = out_q.addr;
  assign inst_data_if_o = out_q.data;
  assign trap_bus_if_o  = out_q.trap;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a linear sequence of steps with
// hand-computed expected values checked by immediate assertions.

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_valid = 6'd0;
  logic [5:0]  flush_valid = 6'd0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        inst_valid;
  logic [63:0] inst_addr;
  logic [31:0] inst_data;
  logic [7:0]  trap_bus;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_if imem_bus ();

  inst_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .stall_valid_i    (stall_valid),
    .flush_valid_i    (flush_valid),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem             (imem_bus),
    .inst_valid_o     (inst_valid),
    .inst_addr_if_o   (inst_addr),
    .inst_data_if_o   (inst_data),
    .trap_bus_if_o    (trap_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resp(input logic v, input logic [31:0] d, input logic e);
    imem_bus.resp_valid = v;
    imem_bus.resp_data  = d;
    imem_bus.resp_err   = e;
  endtask

  initial begin
    imem_bus.req_ready = 1'b0;
    resp(1'b0, 32'h0, 1'b0);

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_req_valid", imem_bus.req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_addr", inst_addr, 64'h0);
    chk("rst_inst_data", inst_data, 32'h0000_0013);
    chk("rst_trap", trap_bus, 8'h00);
    tick();
    tick();
    chk("rst_hold_req_valid", imem_bus.req_valid, 1'b0);

    // First fetch; stall is raised early so the first output is held.
    rst = 1'b1;
    imem_bus.req_ready = 1'b1;
    tick();
    chk("first_req_valid", imem_bus.req_valid, 1'b1);
    chk("first_req_addr", imem_bus.req_addr, 64'h8000_0000);
    stall_valid = 6'b000001;
    tick();
    chk("wait_req_valid", imem_bus.req_valid, 1'b0);
    resp(1'b1, 32'h0000_0093, 1'b0);
    tick();
    chk("out0_valid", inst_valid, 1'b1);
    chk("out0_addr", inst_addr, 64'h8000_0000);
    chk("out0_data", inst_data, 32'h0000_0093);
    chk("out0_trap", trap_bus, 8'h00);

    // Stall held 5 cycles; a stray response in OUT must be ignored.
    resp(1'b1, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", inst_valid, 1'b1);
      chk("stall_addr", inst_addr, 64'h8000_0000);
      chk("stall_data", inst_data, 32'h0000_0093);
      chk("stall_no_req", imem_bus.req_valid, 1'b0);
      chk("stall_pc", imem_bus.req_addr, 64'h8000_0000);
    end
    resp(1'b0, 32'h0, 1'b0);
    stall_valid = 6'b000000;
    tick();
    chk("consume_valid", inst_valid, 1'b0);
    chk("consume_data", inst_data, 32'h0000_0013);
    chk("consume_addr", inst_addr, 64'h0);
    chk("next_req_valid", imem_bus.req_valid, 1'b1);
    chk("next_req_addr", imem_bus.req_addr, 64'h8000_0004);

    // Plain fetch of 0x80000004.
    tick();
    resp(1'b1, 32'h0010_0113, 1'b0);
    tick();
    resp(1'b0, 32'h0, 1'b0);
    chk("out1_addr", inst_addr, 64'h8000_0004);
    chk("out1_data", inst_data, 32'h0010_0113);
    tick();
    chk("req2_addr", imem_bus.req_addr, 64'h8000_0008);

    // Access fault at 0x80000008.
    tick();
    resp(1'b1, 32'hDEAD_BEEF, 1'b1);
    tick();
    resp(1'b0, 32'h0, 1'b0);
    chk("err_valid", inst_valid, 1'b1);
    chk("err_addr", inst_addr, 64'h8000_0008);
    chk("err_data", inst_data, 32'h0000_0013);
    chk("err_trap", trap_bus, 8'h02);
    tick();
    chk("req3_addr", imem_bus.req_addr, 64'h8000_000C);

    // Redirect while WAIT: the late response is dropped.
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    chk("kill_no_req", imem_bus.req_valid, 1'b0);
    chk("kill_inst_valid", inst_valid, 1'b0);
    resp(1'b1, 32'h1111_1111, 1'b0);
    tick();
    resp(1'b0, 32'h0, 1'b0);
    chk("drop_inst_valid", inst_valid, 1'b0);
    chk("drop_inst_data", inst_data, 32'h0000_0013);
    chk("redir_req_valid", imem_bus.req_valid, 1'b1);
    chk("redir_req_addr", imem_bus.req_addr, 64'h8000_1000);
    tick();
    resp(1'b1, 32'h2222_2293, 1'b0);
    tick();
    resp(1'b0, 32'h0, 1'b0);
    chk("redir_out_addr", inst_addr, 64'h8000_1000);
    chk("redir_out_data", inst_data, 32'h2222_2293);
    tick();
    chk("req4_addr", imem_bus.req_addr, 64'h8000_1004);

    // Request held without ready keeps its address.
    imem_bus.req_ready = 1'b0;
    tick();
    chk("hold_req_valid", imem_bus.req_valid, 1'b1);
    chk("hold_req_addr", imem_bus.req_addr, 64'h8000_1004);

    // Redirect to a misaligned PC: trap without a request.
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0002;
    tick();
    redirect_valid = 1'b0;
    chk("mis_no_req", imem_bus.req_valid, 1'b0);
    chk("mis_pre_valid", inst_valid, 1'b0);
    tick();
    chk("mis_valid", inst_valid, 1'b1);
    chk("mis_addr", inst_addr, 64'h8000_0002);
    chk("mis_data", inst_data, 32'h0000_0013);
    chk("mis_trap", trap_bus, 8'h01);
    chk("mis_no_req2", imem_bus.req_valid, 1'b0);
    tick();
    chk("mis_consumed", inst_valid, 1'b0);
    tick();
    chk("mis2_valid", inst_valid, 1'b1);
    chk("mis2_addr", inst_addr, 64'h8000_0006);

    // Redirect overrides stall in OUT.
    stall_valid = 6'b000001;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    tick();
    stall_valid = 6'b000000;
    redirect_valid = 1'b0;
    chk("rds_inst_valid", inst_valid, 1'b0);
    chk("rds_req_valid", imem_bus.req_valid, 1'b1);
    chk("rds_req_addr", imem_bus.req_addr, 64'h8000_0100);

    // Flush while WAIT: response dropped, same PC refetched.
    imem_bus.req_ready = 1'b1;
    tick();
    flush_valid = 6'b000001;
    tick();
    flush_valid = 6'b000000;
    chk("flush_inst_valid", inst_valid, 1'b0);
    chk("flush_no_req", imem_bus.req_valid, 1'b0);
    resp(1'b1, 32'h6666_6666, 1'b0);
    tick();
    resp(1'b0, 32'h0, 1'b0);
    chk("flush_drop_valid", inst_valid, 1'b0);
    chk("flush_refetch_valid", imem_bus.req_valid, 1'b1);
    chk("flush_refetch_addr", imem_bus.req_addr, 64'h8000_0100);

    // Flush and stall together in OUT: flush wins, PC unchanged.
    tick();
    resp(1'b1, 32'h3333_3313, 1'b0);
    tick();
    resp(1'b0, 32'h0, 1'b0);
    chk("fs_out_valid", inst_valid, 1'b1);
    chk("fs_out_data", inst_data, 32'h3333_3313);
    stall_valid = 6'b000001;
    flush_valid = 6'b000001;
    tick();
    stall_valid = 6'b000000;
    flush_valid = 6'b000000;
    chk("fs_inst_valid", inst_valid, 1'b0);
    chk("fs_req_valid", imem_bus.req_valid, 1'b1);
    chk("fs_req_addr", imem_bus.req_addr, 64'h8000_0100);

    // Reset during WAIT; response after release is ignored.
    tick();
    chk("rw_wait", imem_bus.req_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("rw_async_req", imem_bus.req_valid, 1'b0);
    chk("rw_async_valid", inst_valid, 1'b0);
    tick();
    rst = 1'b1;
    resp(1'b1, 32'h4444_4444, 1'b0);
    tick();
    resp(1'b0, 32'h0, 1'b0);
    chk("rw_ignored_valid", inst_valid, 1'b0);
    chk("rw_req_valid", imem_bus.req_valid, 1'b1);
    chk("rw_req_addr", imem_bus.req_addr, 64'h8000_0000);
    tick();
    resp(1'b1, 32'h5555_5593, 1'b0);
    tick();
    resp(1'b0, 32'h0, 1'b0);
    chk("rw_out_valid", inst_valid, 1'b1);
    chk("rw_out_addr", inst_addr, 64'h8000_0000);
    chk("rw_out_data", inst_data, 32'h5555_5593);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
